// File: rtl/fifo_pkg.sv
// Shared async FIFO definitions: default depth, pointer/address types and
// binary/gray conversion helpers used by the write- and read-side controllers.
package fifo_pkg;

    localparam int FIFO_DEPTH_BIT_DEFAULT = 4;
    localparam int ALMOST_FULL_TH_DEFAULT = 12;

    localparam int PTR_W  = FIFO_DEPTH_BIT_DEFAULT + 1;
    localparam int ADDR_W = FIFO_DEPTH_BIT_DEFAULT;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray to binary converter. Each binary bit is the XOR of all gray bits at
// and above it, i.e. the MSB-first prefix XOR of the gray code.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and full-flag controller of the async FIFO (w_clk domain).
// read_addr_gray_sync must already be synchronized into w_clk; no sync flops here.
// Optional macro FIFO_WR_LEVEL_EN adds the registered wr_level / almost_full
// status (and the gray-to-binary converter they need); otherwise both are 0.
module async_fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH_BIT = FIFO_DEPTH_BIT_DEFAULT,
    parameter int ALMOST_FULL_TH = ALMOST_FULL_TH_DEFAULT
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic                      w_en,
    input  logic [FIFO_DEPTH_BIT:0]   read_addr_gray_sync,
    output logic [FIFO_DEPTH_BIT:0]   write_addr_gray,
    output logic                      mem_we,
    output logic [FIFO_DEPTH_BIT-1:0] mem_waddr,
    output logic                      full,
    output logic                      wr_err,
    output logic                      almost_full,
    output logic [FIFO_DEPTH_BIT:0]   wr_level
);

    localparam int N = FIFO_DEPTH_BIT;

    logic [N:0] wptr_bin;
    logic [N:0] wptr_next;
    logic [N:0] gray_next;
    logic [N:0] full_match;
    logic       accept;

    // A threshold above the depth is legal but almost_full can then never assert.
    if (ALMOST_FULL_TH > (1 << FIFO_DEPTH_BIT)) begin : g_af_th_unreachable
    end

    assign accept     = w_en & ~full;
    // full is already 0 during reset, so w_rst gating is what drops an in-flight write.
    assign mem_we     = accept & ~w_rst;
    assign mem_waddr  = wptr_bin[N-1:0];
    assign wptr_next  = wptr_bin + {{N{1'b0}}, accept};
    assign gray_next  = wptr_next ^ (wptr_next >> 1);
    // Full when write pointer is exactly one lap ahead: top two gray bits inverted.
    assign full_match = {~read_addr_gray_sync[N:N-1], read_addr_gray_sync[N-2:0]};

    // Pointer, published gray pointer, full and overflow-error registers.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wptr_bin        <= '0;
            write_addr_gray <= '0;
            full            <= 1'b0;
            wr_err          <= 1'b0;
        end else begin
            wptr_bin        <= wptr_next;
            write_addr_gray <= gray_next;
            full            <= (gray_next == full_match);
            wr_err          <= w_en & full;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    logic [N:0] rptr_bin;
    logic [N:0] level_next;

    fifo_gray2bin #(
        .WIDTH (N + 1)
    ) u_rsync_g2b (
        .gray (read_addr_gray_sync),
        .bin  (rptr_bin)
    );

    // Modulo subtraction gives occupancy 0..2**N directly, wrap included.
    assign level_next = wptr_next - rptr_bin;

    // Occupancy and almost_full, registered on the same edge as full.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_level    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_level    <= level_next;
            almost_full <= ({1'b0, level_next} >= (N + 2)'(ALMOST_FULL_TH));
        end
    end
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed phases plus random traffic, checked by
// a queue-based scoreboard against an occupancy-arithmetic reference model.
module tb_async_fifo_wr_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AF_TH = 12;
`ifdef FIFO_WR_LEVEL_EN
    localparam bit LEVEL_EN = 1'b1;
`else
    localparam bit LEVEL_EN = 1'b0;
`endif

    logic         w_clk = 1'b0;
    logic         w_rst = 1'b1;
    logic         w_en  = 1'b0;
    logic [N:0]   read_addr_gray_sync = '0;
    logic [N:0]   write_addr_gray;
    logic         mem_we;
    logic [N-1:0] mem_waddr;
    logic         full;
    logic         wr_err;
    logic         almost_full;
    logic [N:0]   wr_level;

    always #5 w_clk = ~w_clk;

    async_fifo_wr_ctrl #(
        .FIFO_DEPTH_BIT (N),
        .ALMOST_FULL_TH (AF_TH)
    ) dut (
        .w_clk               (w_clk),
        .w_rst               (w_rst),
        .w_en                (w_en),
        .read_addr_gray_sync (read_addr_gray_sync),
        .write_addr_gray     (write_addr_gray),
        .mem_we              (mem_we),
        .mem_waddr           (mem_waddr),
        .full                (full),
        .wr_err              (wr_err),
        .almost_full         (almost_full),
        .wr_level            (wr_level)
    );

    typedef struct {
        int we;
        int waddr;
        int gray;
        int full;
        int err;
        int level;
        int af;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: write pointer count modulo 2*DEPTH plus registered flags.
    int m_wptr, m_full, m_err, m_level, m_af, m_total;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wptr  = 0;
        m_full  = 0;
        m_err   = 0;
        m_level = 0;
        m_af    = 0;
        m_total = 0;
    endtask

    // One cycle: apply w_en and read pointer rp (binary), queue expectations, advance model.
    task automatic drive(input int en, input int rp);
        exp_t e;
        int acc, nxt, occ, old_full;
        @(posedge w_clk);
        #1;
        w_en = (en != 0);
        read_addr_gray_sync = 5'(gray(rp % PMOD));
        e.we    = (en != 0 && m_full == 0) ? 1 : 0;
        e.waddr = m_wptr % DEPTH;
        e.gray  = gray(m_wptr);
        e.full  = m_full;
        e.err   = m_err;
        e.level = m_level;
        e.af    = m_af;
        sb_q.push_back(e);
        acc      = e.we;
        nxt      = (m_wptr + acc) % PMOD;
        occ      = (nxt - (rp % PMOD) + PMOD) % PMOD;
        old_full = m_full;
        m_full   = (occ == DEPTH) ? 1 : 0;
        m_err    = (en != 0 && old_full != 0) ? 1 : 0;
        m_level  = LEVEL_EN ? occ : 0;
        m_af     = (LEVEL_EN && occ >= AF_TH) ? 1 : 0;
        m_wptr   = nxt;
        m_total += acc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"}, int'(mem_we), 0);
        check({tag, "_mem_waddr"}, int'(mem_waddr), 0);
        check({tag, "_wgray"}, int'(write_addr_gray), 0);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_wr_err"}, int'(wr_err), 0);
        check({tag, "_wr_level"}, int'(wr_level), 0);
        check({tag, "_almost_full"}, int'(almost_full), 0);
    endtask

    // Assert reset between edges with a write pending; outputs must clear at once.
    task automatic reset_midop();
        @(negedge w_clk);
        #2;
        w_en  = 1'b1;
        w_rst = 1'b1;
        #1;
        check_all_zero("rst_midop");
        @(posedge w_clk);
        #1;
        w_en  = 1'b0;
        read_addr_gray_sync = '0;
        w_rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    initial begin
        forever begin
            @(negedge w_clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("mem_we", int'(mem_we), mon_e.we);
                check("mem_waddr", int'(mem_waddr), mon_e.waddr);
                check("write_addr_gray", int'(write_addr_gray), mon_e.gray);
                check("full", int'(full), mon_e.full);
                check("wr_err", int'(wr_err), mon_e.err);
                check("wr_level", int'(wr_level), mon_e.level);
                check("almost_full", int'(almost_full), mon_e.af);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rp;
        int read_pct;
        model_reset();
        w_rst = 1'b1;
        repeat (2) @(posedge w_clk);
        #1;
        check_all_zero("rst_init");
        w_rst = 1'b0;

        // Fill from empty, then overflow attempts.
        for (int i = 0; i < DEPTH; i++) drive(1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0);

        // Release by one read: blocked, then one write accepted, full again.
        drive(1, 1);
        drive(1, 1);
        drive(0, 1);
        drive(1, 1);
        drive(0, 1);

        reset_midop();

        // Wrap with the read pointer trailing by two.
        for (int i = 0; i < 40; i++) drive(1, (m_total >= 2) ? (m_total - 2) : 0);
        drive(0, (m_total - 2));

        reset_midop();

        // Occupancy threshold scenario.
        for (int i = 0; i < 12; i++) drive(1, 0);
        drive(0, 0);
        for (int i = 0; i < 3; i++) drive(0, 4);

        // Random traffic, slow then fast reader.
        rp = 4;
        for (int ph = 0; ph < 2; ph++) begin
            read_pct = (ph == 0) ? 30 : 80;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 99) < read_pct &&
                    ((m_wptr - rp + PMOD) % PMOD) != 0)
                    rp = (rp + 1) % PMOD;
                drive(($urandom_range(0, 3) != 0) ? 1 : 0, rp);
            end
        end
        drive(0, rp);

        @(negedge w_clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
